accel_cmd_issuer: RTL
=====================

# accel_cmd_issuer

Hardware initiator for the accelerator custom-instruction interface. It takes queued commands (instruction word, rs1, rs2, rd, writeback flag) from a local master such as a DMA or microcontroller shim, and drives them one at a time into `layer_sequencer`'s `instr_valid`/`instr_ready` port. It also collects the matching `rd_we` writebacks into a response queue. It replaces the CPU as the issuing end of the protocol, so layers can run without core involvement.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `RSP_DEPTH`, 4: response FIFO entries (power of two, ≥2)
- `TIMEOUT`, 1024: max cycles spent in WAIT_WB before a timeout response (≥2)

- `clk`  in  1  single clock; all logic is posedge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  equals `!cmd_full`
- `cmd_instr`  in  32  R-type instruction word (opcode 7'h33, funct3, funct7)
- `cmd_rs1`, `cmd_rs2`  in  32  operand values
- `cmd_rd`  in  5  destination register
- `cmd_wb`  in  1  command expects a writeback
- `instr_valid`  out  1  to accelerator
- `instr_ready`  in  1  from accelerator
- `instr`, `rs1_val`, `rs2_val`  out  32  payload
- `rd_addr`  out  5  payload
- `rd_we`  in  1  accelerator writeback strobe
- `rd_waddr`  in  5  writeback register
- `rd_wdata`  in  32  writeback data
- `rsp_valid`  out  1  response FIFO non-empty
- `rsp_ready`  in  1  response pop
- `rsp_data`  out  32  captured `rd_wdata`, or 0 on timeout
- `rsp_rd`  out  5  register tag
- `rsp_timeout`  out  1  response produced by timeout
- `busy`  out  1  `state!=IDLE || !cmd_empty`
- `err_sticky`  out  1  stray, mismatched or timed-out writeback seen
- `err_clr`  in  1  clears `err_sticky`

## Operation
- **Command FIFO.** A push occurs on `cmd_valid && cmd_ready`. Full FIFO: `cmd_ready=0` and `cmd_valid` is ignored. Pointers wrap modulo `CMD_DEPTH`.
- **Effective writeback.** `eff_wb = cmd_wb && cmd_rd!=0`. A command with rd=x0 never produces a response.
- **FSM states:** IDLE, ISSUE, WAIT_WB.
- **IDLE.** The head command is popped only if the FIFO is non-empty and either `!eff_wb` or `rsp_count < RSP_DEPTH`. On pop, the payload is registered and the FSM moves to ISSUE. Otherwise it stays in IDLE, which stalls on a full response FIFO.
- **ISSUE.** `instr_valid=1` with stable payload until an edge where `instr_ready=1` (acceptance).
  - On acceptance with `!eff_wb`: go to IDLE.
  - On acceptance with `eff_wb`: if `rd_we && rd_waddr==rd_addr` on that same edge, capture and push the response, then go to IDLE. Otherwise go to WAIT_WB with the timer cleared.
- **WAIT_WB.** The timer increments each cycle.
  - Matching `rd_we`: push `{rd_wdata, rd_addr, timeout=0}` and go to IDLE.
  - Timer reaching `TIMEOUT-1` without a match: push `{0, rd_addr, 1}`, set `err_sticky`, go to IDLE.
  - A match and a timeout on the same edge: the match wins.
- **Errors.** `rd_we=1` in IDLE, in ISSUE before acceptance, or with a mismatched `rd_waddr` sets `err_sticky`; the strobe is otherwise ignored. `err_clr` has priority below a same-cycle set (set wins).
- **Response FIFO.**
  - Pop occurs on `rsp_valid && rsp_ready`.
  - A push and pop in the same cycle are both allowed, and `rsp_count` is unchanged.
  - Overflow cannot occur, because space is reserved at the IDLE pop and at most one writeback is outstanding.
- **Single outstanding.** At most one instruction is in flight at a time.

## Timing
- **Reset values:** `instr_valid=0`, payload=0, `cmd_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_rd=0`, `rsp_timeout=0`, `busy=0`, `err_sticky=0`, both FIFOs empty, state=IDLE, timer=0.
- **Reset mid-operation:** takes effect at the next edge. `instr_valid` drops and queued commands and responses are discarded. A late `rd_we` after reset only sets `err_sticky`.
- **Outputs are registered.** `instr_valid` rises at the edge where IDLE pops. With a command pushed at edge t into an empty FIFO, the pop occurs at edge t+1, so `instr_valid` is high during cycle t+1.
- **Handshake.** `instr_valid` falls at the edge after acceptance. The payload does not change while `instr_valid=1`.
- **Back-to-back gap.** Consecutive instructions have at least one cycle with `instr_valid=0` between them (the IDLE cycle).
- **Response latency.** A response is visible (`rsp_valid=1`) the cycle after the capture edge.
- **Throughput** without writeback is one instruction per 2 cycles when `instr_ready` is held high.

## Test plan
- **Write-type, delayed ready.** Issue MAC A-write (funct7=01, funct3=000, rs1=row1/k0, rs2=3f800000, rd=0) with `instr_ready` delayed 3 cycles. Required: `instr_valid` high for exactly 4 cycles with stable payload, no response, `busy` returns to 0.
- **Read-type, delayed writeback.** Issue LAY_STAT (funct7=06, funct3=010, rd=2, wb=1); the accelerator asserts `rd_we` with waddr=2 and wdata=00000002 five cycles after acceptance. Required: one response {00000002, rd=2, timeout=0}.
- **Mismatched writeback.** `rd_we` with waddr=3 while waiting on rd=2, then waddr=2 with wdata=0000000A. Required: `err_sticky=1`, response data 0000000A.
- **Timeout.** `TIMEOUT=16`, no writeback. Required: response {0, rd, 1} exactly 16 cycles after entering WAIT_WB, and `err_sticky=1`.
- **Backpressure.** With `rsp_ready=0`, queue 5 read commands (all answered). Required: 4 responses held and the 5th not issued. With `rsp_ready=1`, the 5th issues and the responses drain in order.
- **Reset in WAIT_WB.** Assert `rst` while in WAIT_WB with 2 commands queued. Required: all outputs at reset values next cycle, and a later `rd_we` only sets `err_sticky`.

Source files
------------

// File: rtl/accel_cmd_issuer.sv
// accel_cmd_issuer
//   Hardware initiator for the accelerator custom-instruction port. Queues
//   commands from a local master, issues them one at a time on the
//   instr_valid/instr_ready handshake, and collects matching rd_we writebacks
//   (or timeout markers) into a response FIFO.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command push handshake (cmd_ready = !full)
//   cmd_instr/rs1/rs2/rd/wb       command payload
//   instr_valid/instr_ready       issue handshake towards the accelerator
//   instr/rs1_val/rs2_val/rd_addr registered issue payload
//   rd_we/rd_waddr/rd_wdata       accelerator writeback strobe
//   rsp_valid/rsp_ready           response pop handshake
//   rsp_data/rsp_rd/rsp_timeout   head response entry
//   busy                          FSM active or commands queued
//   err_sticky/err_clr            stray/mismatched/timed-out writeback flag
module accel_cmd_issuer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  input  logic [4:0]  cmd_rd,
  input  logic        cmd_wb,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  rd_addr,
  input  logic        rd_we,
  input  logic [4:0]  rd_waddr,
  input  logic [31:0] rd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        err_sticky,
  input  logic        err_clr
);

  localparam int CW  = $clog2(CMD_DEPTH);
  localparam int RW  = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int CCW = CW + 1;
  localparam int RCW = RW + 1;
  localparam logic [CW:0]   CMD_CAP = CCW'(CMD_DEPTH);
  localparam logic [RW:0]   RSP_CAP = RCW'(RSP_DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  // wb holds the effective writeback flag (cmd_wb && rd != x0), folded in at push
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        wb;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        timeout;
  } rsp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB} state_t;

  cmd_t          cmd_mem [CMD_DEPTH];
  logic [CW-1:0] cmd_wp, cmd_rp;
  logic [CW:0]   cmd_cnt;
  rsp_t          rsp_mem [RSP_DEPTH];
  logic [RW-1:0] rsp_wp, rsp_rp;
  logic [RW:0]   rsp_cnt;

  state_t        state, state_n;
  cmd_t          cur, head;
  logic [TW-1:0] timer, timer_n;
  logic          cmd_push, cmd_pop, rsp_push, rsp_pop, err_set, match;
  rsp_t          rsp_in;

  assign cmd_ready   = (cmd_cnt != CMD_CAP);
  assign cmd_push    = cmd_valid && cmd_ready;
  assign head        = cmd_mem[cmd_rp];
  assign rsp_valid   = (rsp_cnt != '0);
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign {rsp_data, rsp_rd, rsp_timeout} = rsp_valid ? rsp_mem[rsp_rp] : '0;
  assign instr_valid = (state == ISSUE);
  assign instr       = cur.instr;
  assign rs1_val     = cur.rs1;
  assign rs2_val     = cur.rs2;
  assign rd_addr     = cur.rd;
  assign busy        = (state != IDLE) || (cmd_cnt != '0);
  assign match       = rd_we && (rd_waddr == cur.rd);

  always_comb begin
    state_n = state;
    timer_n = timer;
    cmd_pop = 1'b0;
    rsp_push = 1'b0;
    rsp_in = '0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        err_set = rd_we;
        // response space is reserved here so a later push can never overflow
        if ((cmd_cnt != '0) && (!head.wb || (rsp_cnt != RSP_CAP))) begin
          cmd_pop = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!instr_ready) begin
          err_set = rd_we;
        end else if (!cur.wb) begin
          err_set = rd_we;
          state_n = IDLE;
        end else if (match) begin
          rsp_push = 1'b1;
          rsp_in.data = rd_wdata;
          rsp_in.rd = cur.rd;
          state_n = IDLE;
        end else begin
          err_set = rd_we;
          timer_n = '0;
          state_n = WAIT_WB;
        end
      end
      WAIT_WB: begin
        timer_n = timer + 1'b1;
        if (match) begin
          rsp_push = 1'b1;
          rsp_in.data = rd_wdata;
          rsp_in.rd = cur.rd;
          state_n = IDLE;
        end else begin
          err_set = rd_we;
          if (timer == T_LAST) begin
            rsp_push = 1'b1;
            rsp_in.rd = cur.rd;
            rsp_in.timeout = 1'b1;
            err_set = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cur <= '0;
      cmd_wp <= '0;
      cmd_rp <= '0;
      cmd_cnt <= '0;
      rsp_wp <= '0;
      rsp_rp <= '0;
      rsp_cnt <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (cmd_pop) cur <= head;
      if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
      if (cmd_pop) cmd_rp <= cmd_rp + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: ;
      endcase
      if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
      if (rsp_pop) rsp_rp <= rsp_rp + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
        2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
        default: ;
      endcase
      if (err_set) err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

  // storage only; validity is tracked by the reset pointers and counts
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {cmd_instr, cmd_rs1, cmd_rs2, cmd_rd, cmd_wb && (cmd_rd != 5'd0)};
    if (rsp_push) rsp_mem[rsp_wp] <= rsp_in;
  end

endmodule
